// File: rtl/cpu_input_port.sv
// Memory-mapped 8-bit input port: synchronised pins, per-bit edge latch (W1C), mask/polarity, level IRQ.
// Optional INPUT_PORT_DEBOUNCE_EN adds a per-bit debounce counter in front of the accepted level.
module cpu_input_port #(
    parameter int unsigned SYNC_STAGES = 2
`ifdef INPUT_PORT_DEBOUNCE_EN
    , parameter int unsigned DEBOUNCE_CYCLES = 1023
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       read,
    input  logic       write,
    input  logic [1:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic [7:0] pins,
    output logic       irq
);

    localparam int unsigned W = 8;
`ifdef INPUT_PORT_DEBOUNCE_EN
    // The registered accepted level adds one cycle before prev/cur settle.
    localparam int unsigned INH_CYCLES = SYNC_STAGES + 2;
`else
    localparam int unsigned INH_CYCLES = SYNC_STAGES + 1;
`endif
    localparam int unsigned INH_W = $clog2(INH_CYCLES + 1);

    localparam logic [1:0] A_PIN  = 2'd0;
    localparam logic [1:0] A_EDGE = 2'd1;
    localparam logic [1:0] A_MASK = 2'd2;
    localparam logic [1:0] A_POL  = 2'd3;

    logic [W-1:0]     sync_q [SYNC_STAGES];
    logic [W-1:0]     sync_last;
    logic [W-1:0]     acc;
    logic [INH_W-1:0] inh_q;
    logic             det_en;

    logic [W-1:0] prev_q;
    logic [W-1:0] edge_q, edge_d;
    logic [W-1:0] mask_q, mask_d;
    logic [W-1:0] pol_q, pol_d;
    logic [W-1:0] data_out_q, data_out_d;
    logic         irq_q, irq_d;
    logic         wr_q;
    logic         wr_pulse;
    logic [W-1:0] clr;
    logic [W-1:0] ev;

    // Pin synchroniser chain
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= pins;
            for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];

    // Post-reset detection inhibit: lets the pipeline fill without a false edge
    always_ff @(posedge clk) begin
        if (reset)        inh_q <= '0;
        else if (!det_en) inh_q <= inh_q + INH_W'(1);
    end

    assign det_en = (inh_q == INH_W'(INH_CYCLES));

`ifdef INPUT_PORT_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q [W];
    logic [CNT_W-1:0] cnt_d [W];
    logic [W-1:0]     acc_q, acc_d;

    // A differing level must persist DEBOUNCE_CYCLES clks; any bounce back restarts the count
    always_comb begin
        acc_d = acc_q;
        for (int i = 0; i < int'(W); i++) begin
            cnt_d[i] = '0;
            if (!det_en) begin
                acc_d[i] = sync_last[i];
            end else if (sync_last[i] != acc_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) acc_d[i] = sync_last[i];
                else                                         cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            for (int i = 0; i < int'(W); i++) cnt_q[i] <= '0;
        end else begin
            acc_q <= acc_d;
            for (int i = 0; i < int'(W); i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign acc = acc_q;
`else
    assign acc = sync_last;
`endif

    assign wr_pulse = write & ~wr_q;
    // Event: level changed and new level is the one selected by POL (0 rising, 1 falling)
    assign ev       = (prev_q ^ acc) & (acc ^ pol_q) & {W{det_en}};
    assign clr      = (wr_pulse && addr == A_EDGE) ? data_in : '0;

    always_comb begin
        edge_d     = (edge_q & ~clr) | ev;
        mask_d     = mask_q;
        pol_d      = pol_q;
        irq_d      = |(edge_q & mask_q);
        data_out_d = data_out_q;

        if (wr_pulse && addr == A_MASK) mask_d = data_in;
        if (wr_pulse && addr == A_POL)  pol_d  = data_in;

        if (read) begin
            case (addr)
                A_PIN:   data_out_d = acc;
                A_EDGE:  data_out_d = edge_q;
                A_MASK:  data_out_d = mask_q;
                default: data_out_d = pol_q;
            endcase
        end
    end

    // Strobe history tracks through reset so a strobe held across release is not a new edge
    always_ff @(posedge clk) begin
        wr_q <= write;
        if (reset) begin
            prev_q     <= '0;
            edge_q     <= '0;
            mask_q     <= '0;
            pol_q      <= '0;
            irq_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            prev_q     <= acc;
            edge_q     <= edge_d;
            mask_q     <= mask_d;
            pol_q      <= pol_d;
            irq_q      <= irq_d;
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_cpu_input_port.sv
// Self-checking bench for cpu_input_port; expected register values are queued and popped on read-back.
module tb_cpu_input_port;

    logic       clk = 1'b0;
    logic       reset;
    logic       read;
    logic       write;
    logic [1:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic [7:0] pins;
    logic       irq;

    int checks   = 0;
    int failures = 0;
    logic [7:0] sb[$];

    cpu_input_port #(
        .SYNC_STAGES(2)
`ifdef INPUT_PORT_DEBOUNCE_EN
        , .DEBOUNCE_CYCLES(8)
`endif
    ) dut (
        .clk(clk), .reset(reset), .read(read), .write(write), .addr(addr),
        .data_in(data_in), .data_out(data_out), .pins(pins), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(posedge clk); #1 read = 1'b1; addr = a;
        repeat (2) @(posedge clk);
        #1 read = 1'b0;
        @(negedge clk);
        d = data_out;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input int n);
        @(posedge clk); #1 write = 1'b1; addr = a; data_in = d;
        repeat (n) @(posedge clk);
        #1 write = 1'b0;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic test_reset;
        logic [7:0] got, exp;
        reset = 1'b1; read = 1'b0; write = 1'b0; addr = 2'd0; data_in = 8'h00; pins = 8'hA5;
        wait_clk(3);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        wait_clk(5);
        sb.push_back(8'hA5); sb.push_back(8'h00); sb.push_back(8'h00); sb.push_back(8'h00);
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), got);
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin failures++; $display("FAIL reset_reg%0d got=%h exp=%h", a, got, exp); end
        end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL reset_no_false_irq got=%b exp=0", irq); end
    endtask

    task automatic test_rise_irq;
        logic [7:0] got, exp;
        bus_write(2'd3, 8'h00, 2);
        bus_write(2'd2, 8'h01, 2);
        @(posedge clk); #1 pins[0] = 1'b0;
        wait_clk(5);
        sb.push_back(8'h00);
        bus_read(2'd1, got); exp = sb.pop_front();
        checks++;
        if (got !== exp) begin failures++; $display("FAIL fall_pol0_no_edge got=%h exp=%h", got, exp); end
        @(posedge clk); #1 pins[0] = 1'b1;
        wait_clk(3);
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_lags_edge got=%b exp=0", irq); end
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_rise got=%b exp=1", irq); end
        sb.push_back(8'h01);
        bus_read(2'd1, got); exp = sb.pop_front();
        checks++;
        if (got !== exp) begin failures++; $display("FAIL edge_rise got=%h exp=%h", got, exp); end
        @(posedge clk); #1 write = 1'b1; addr = 2'd1; data_in = 8'h01;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_hold_clear_cycle got=%b exp=1", irq); end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_after_clear got=%b exp=0", irq); end
        @(posedge clk); #1 write = 1'b0;
        sb.push_back(8'h00);
        bus_read(2'd1, got); exp = sb.pop_front();
        checks++;
        if (got !== exp) begin failures++; $display("FAIL edge_w1c got=%h exp=%h", got, exp); end
    endtask

    task automatic test_addr0_and_pol_change;
        logic [7:0] got, exp;
        bus_write(2'd0, 8'h00, 2);
        sb.push_back(pins);
        bus_read(2'd0, got); exp = sb.pop_front();
        checks++;
        if (got !== exp) begin failures++; $display("FAIL addr0_write_ignored got=%h exp=%h", got, exp); end
        bus_write(2'd3, 8'h04, 2);
        wait_clk(4);
        sb.push_back(8'h04); sb.push_back(8'h00);
        bus_read(2'd3, got); exp = sb.pop_front();
        checks++;
        if (got !== exp) begin failures++; $display("FAIL pol_rw got=%h exp=%h", got, exp); end
        bus_read(2'd1, got); exp = sb.pop_front();
        checks++;
        if (got !== exp) begin failures++; $display("FAIL pol_change_no_edge got=%h exp=%h", got, exp); end
        bus_write(2'd3, 8'h00, 2);
    endtask

    task automatic test_falling;
        logic [7:0] got, exp;
        bus_write(2'd3, 8'h80, 2);
        @(posedge clk); #1 pins[7] = 1'b0;
        wait_clk(6);
        sb.push_back(8'h80);
        bus_read(2'd1, got); exp = sb.pop_front();
        checks++;
        if (got !== exp) begin failures++; $display("FAIL edge_fall got=%h exp=%h", got, exp); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL masked_irq got=%b exp=0", irq); end
        @(posedge clk); #1 pins[7] = 1'b1;
        wait_clk(6);
        sb.push_back(8'h80);
        bus_read(2'd1, got); exp = sb.pop_front();
        checks++;
        if (got !== exp) begin failures++; $display("FAIL rise_pol1_no_edge got=%h exp=%h", got, exp); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL masked_irq2 got=%b exp=0", irq); end
        bus_write(2'd1, 8'hFF, 3);
        bus_write(2'd3, 8'h00, 2);
    endtask

    task automatic test_back_to_back;
        logic [7:0] got, exp;
        // event lands on the 2nd cycle of a held W1C strobe
        @(posedge clk); #1 pins[3] = 1'b1;
        @(posedge clk); #1 write = 1'b1; addr = 2'd1; data_in = 8'hFF;
        wait_clk(4);
        #1 write = 1'b0;
        sb.push_back(8'h08);
        bus_read(2'd1, got); exp = sb.pop_front();
        checks++;
        if (got !== exp) begin failures++; $display("FAIL w1c_single_action got=%h exp=%h", got, exp); end
        @(posedge clk); #1 pins[3] = 1'b0;
        wait_clk(4);
        bus_write(2'd1, 8'hFF, 3);
        sb.push_back(8'h00);
        bus_read(2'd1, got); exp = sb.pop_front();
        checks++;
        if (got !== exp) begin failures++; $display("FAIL w1c_pre_clear got=%h exp=%h", got, exp); end
        // event and clear on the same edge: set wins
        @(posedge clk); #1 pins[3] = 1'b1;
        wait_clk(2);
        #1 write = 1'b1; addr = 2'd1; data_in = 8'h08;
        wait_clk(3);
        #1 write = 1'b0;
        sb.push_back(8'h08);
        bus_read(2'd1, got); exp = sb.pop_front();
        checks++;
        if (got !== exp) begin failures++; $display("FAIL set_wins_over_clear got=%h exp=%h", got, exp); end
        bus_write(2'd1, 8'hFF, 2);
    endtask

    task automatic test_reset_mid_strobe;
        logic [7:0] got, exp;
        @(posedge clk); #1 write = 1'b1; addr = 2'd2; data_in = 8'hFF;
        wait_clk(2);
        #1 reset = 1'b1;
        wait_clk(2);
        #1 reset = 1'b0;
        wait_clk(3);
        #1 write = 1'b0;
        wait_clk(4);
        sb.push_back(8'h00); sb.push_back(8'h00); sb.push_back(8'h00);
        bus_read(2'd2, got); exp = sb.pop_front();
        checks++;
        if (got !== exp) begin failures++; $display("FAIL mask_after_reset got=%h exp=%h", got, exp); end
        bus_read(2'd3, got); exp = sb.pop_front();
        checks++;
        if (got !== exp) begin failures++; $display("FAIL pol_after_reset got=%h exp=%h", got, exp); end
        bus_read(2'd1, got); exp = sb.pop_front();
        checks++;
        if (got !== exp) begin failures++; $display("FAIL edge_after_reset got=%h exp=%h", got, exp); end
        bus_write(2'd2, 8'h3C, 2);
        sb.push_back(8'h3C);
        bus_read(2'd2, got); exp = sb.pop_front();
        checks++;
        if (got !== exp) begin failures++; $display("FAIL mask_write_after_reset got=%h exp=%h", got, exp); end
        bus_write(2'd2, 8'h00, 2);
    endtask

`ifdef INPUT_PORT_DEBOUNCE_EN
    task automatic test_debounce;
        logic [7:0] got, exp, before;
        before = pins;
        bus_write(2'd3, 8'h04, 2);
        bus_write(2'd1, 8'hFF, 2);
        @(posedge clk); #1 pins[2] = ~pins[2];
        wait_clk(5);
        #1 pins[2] = ~pins[2];
        wait_clk(15);
        sb.push_back(before); sb.push_back(8'h00);
        bus_read(2'd0, got); exp = sb.pop_front();
        checks++;
        if (got !== exp) begin failures++; $display("FAIL glitch_pin got=%h exp=%h", got, exp); end
        bus_read(2'd1, got); exp = sb.pop_front();
        checks++;
        if (got !== exp) begin failures++; $display("FAIL glitch_edge got=%h exp=%h", got, exp); end
        @(posedge clk); #1 pins[2] = 1'b0;
        wait_clk(20);
        sb.push_back(before & 8'hFB); sb.push_back(8'h04);
        bus_read(2'd0, got); exp = sb.pop_front();
        checks++;
        if (got !== exp) begin failures++; $display("FAIL debounced_pin got=%h exp=%h", got, exp); end
        bus_read(2'd1, got); exp = sb.pop_front();
        checks++;
        if (got !== exp) begin failures++; $display("FAIL debounced_edge got=%h exp=%h", got, exp); end
    endtask
`endif

    initial begin
        test_reset;
`ifdef INPUT_PORT_DEBOUNCE_EN
        test_reset_mid_strobe;
        test_debounce;
`else
        test_rise_irq;
        test_addr0_and_pol_change;
        test_falling;
        test_back_to_back;
        test_reset_mid_strobe;
`endif
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
